// File: rtl/clk_div_bank.sv
// Bank of NUM_CH run-time programmable 50%-duty clock dividers with tick pulses.
// Define CLK_DIV_BANK_READBACK_EN to add the div_rdata/div_pending readback ports.
module clk_div_bank #(
   parameter int                        NUM_CH    = 4,
   parameter int                        CNT_W     = 32,
   parameter logic [NUM_CH*CNT_W-1:0]   INIT_HALF = {4{32'd49_999}},
   parameter int                        SEL_W     = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              sync_restart,
   input  logic              div_we,
   input  logic [SEL_W-1:0]  div_sel,
   input  logic [CNT_W-1:0]  div_wdata,
`ifdef CLK_DIV_BANK_READBACK_EN
   output logic [CNT_W-1:0]  div_rdata,
   output logic              div_pending,
`endif
   output logic [NUM_CH-1:0] clk_out,
   output logic [NUM_CH-1:0] tick
);

   logic [CNT_W-1:0]  cnt_q    [NUM_CH];
   logic [CNT_W-1:0]  cnt_d    [NUM_CH];
   logic [CNT_W-1:0]  half_q   [NUM_CH];
   logic [CNT_W-1:0]  half_d   [NUM_CH];
   logic [CNT_W-1:0]  shadow_q [NUM_CH];
   logic [CNT_W-1:0]  shadow_d [NUM_CH];
   logic [NUM_CH-1:0] pend_q;
   logic [NUM_CH-1:0] pend_d;
   logic [NUM_CH-1:0] clk_q;
   logic [NUM_CH-1:0] clk_d;
   logic [NUM_CH-1:0] tick_q;
   logic [NUM_CH-1:0] tick_d;
   logic [31:0]       sel_ext;

   assign sel_ext = 32'(div_sel);

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         cnt_d[i]    = cnt_q[i];
         half_d[i]   = half_q[i];
         shadow_d[i] = shadow_q[i];
         pend_d[i]   = pend_q[i];
         clk_d[i]    = clk_q[i];
         tick_d[i]   = 1'b0;
         if (sync_restart) begin
            cnt_d[i] = '0;
            clk_d[i] = 1'b0;
            if (pend_q[i]) begin
               half_d[i] = shadow_q[i];
               pend_d[i] = 1'b0;
            end
         end else if (en) begin
            if (cnt_q[i] == half_q[i]) begin
               cnt_d[i]  = '0;
               clk_d[i]  = ~clk_q[i];
               tick_d[i] = ~clk_q[i];
               if (pend_q[i]) begin
                  half_d[i] = shadow_q[i];
                  pend_d[i] = 1'b0;
               end
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
         // A write lands after any commit, so it waits for the next wrap.
         if (div_we && (sel_ext == 32'(i))) begin
            shadow_d[i] = div_wdata;
            pend_d[i]   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CH; i++) begin
            cnt_q[i]    <= '0;
            half_q[i]   <= INIT_HALF[i*CNT_W +: CNT_W];
            shadow_q[i] <= INIT_HALF[i*CNT_W +: CNT_W];
         end
         pend_q <= '0;
         clk_q  <= '0;
         tick_q <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            cnt_q[i]    <= cnt_d[i];
            half_q[i]   <= half_d[i];
            shadow_q[i] <= shadow_d[i];
         end
         pend_q <= pend_d;
         clk_q  <= clk_d;
         tick_q <= tick_d;
      end
   end

   assign clk_out = clk_q;
   assign tick    = tick_q;

`ifdef CLK_DIV_BANK_READBACK_EN
   always_comb begin
      div_rdata   = '0;
      div_pending = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (sel_ext == 32'(i)) begin
            div_rdata   = half_q[i];
            div_pending = pend_q[i];
         end
      end
   end
`endif

endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank against an event-time reference model.
module tb_clk_div_bank;

   localparam int N = 4;
   localparam int W = 32;
   localparam int S = 3;
   localparam logic [N*W-1:0] INIT = {32'd4, 32'd9, 32'd7, 32'd4};

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          en = 1'b0;
   logic          sync_restart = 1'b0;
   logic          div_we = 1'b0;
   logic [S-1:0]  div_sel = '0;
   logic [W-1:0]  div_wdata = '0;
   logic [N-1:0]  clk_out;
   logic [N-1:0]  tick;
`ifdef CLK_DIV_BANK_READBACK_EN
   logic [W-1:0]  div_rdata;
   logic          div_pending;
`endif

   clk_div_bank #(
      .NUM_CH(N), .CNT_W(W), .INIT_HALF(INIT), .SEL_W(S)
   ) dut (
      .clk(clk), .rst_n(rst_n), .en(en),
      .sync_restart(sync_restart), .div_we(div_we),
      .div_sel(div_sel), .div_wdata(div_wdata),
`ifdef CLK_DIV_BANK_READBACK_EN
      .div_rdata(div_rdata), .div_pending(div_pending),
`endif
      .clk_out(clk_out), .tick(tick)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Model: each channel's next toggle is an absolute count of enabled cycles.
   longint      ecnt;
   longint      dl [N];
   int unsigned mh [N];
   int unsigned ms [N];
   bit          mp [N];
   bit          lvl [N];
   bit          tk [N];

   task automatic mreset();
      ecnt = 0;
      for (int i = 0; i < N; i++) begin
         mh[i]  = INIT[i*W +: W];
         ms[i]  = mh[i];
         mp[i]  = 0;
         lvl[i] = 0;
         tk[i]  = 0;
         dl[i]  = longint'(mh[i]) + 1;
      end
   endtask

   task automatic mstep();
      if (sync_restart) begin
         for (int i = 0; i < N; i++) begin
            if (mp[i]) mh[i] = ms[i];
            mp[i]  = 0;
            lvl[i] = 0;
            tk[i]  = 0;
            dl[i]  = ecnt + longint'(mh[i]) + 1;
         end
      end else if (en) begin
         ecnt++;
         for (int i = 0; i < N; i++) begin
            tk[i] = 0;
            if (ecnt == dl[i]) begin
               tk[i]  = !lvl[i];
               lvl[i] = !lvl[i];
               if (mp[i]) begin
                  mh[i] = ms[i];
                  mp[i] = 0;
               end
               dl[i] = ecnt + longint'(mh[i]) + 1;
            end
         end
      end else begin
         for (int i = 0; i < N; i++) tk[i] = 0;
      end
      if (div_we && int'(div_sel) < N) begin
         ms[div_sel] = div_wdata;
         mp[div_sel] = 1;
      end
   endtask

   task automatic check(input string tag);
      logic [N-1:0] ec, et;
      for (int i = 0; i < N; i++) begin
         ec[i] = lvl[i];
         et[i] = tk[i];
      end
      tests++;
      assert (clk_out === ec) else begin
         fails++;
         $error("FAIL %s clk_out got %b want %b t=%0t", tag, clk_out, ec, $time);
      end
      tests++;
      assert (tick === et) else begin
         fails++;
         $error("FAIL %s tick got %b want %b t=%0t", tag, tick, et, $time);
      end
`ifdef CLK_DIV_BANK_READBACK_EN
      begin
         logic [W-1:0] er;
         logic ep;
         er = '0;
         ep = 1'b0;
         if (int'(div_sel) < N) begin
            er = mh[div_sel];
            ep = mp[div_sel];
         end
         tests++;
         assert (div_rdata === er) else begin
            fails++;
            $error("FAIL %s rdata got %0d want %0d", tag, div_rdata, er);
         end
         tests++;
         assert (div_pending === ep) else begin
            fails++;
            $error("FAIL %s pending got %b want %b", tag, div_pending, ep);
         end
      end
`endif
   endtask

   task automatic cyc(input string tag);
      @(posedge clk);
      if (rst_n) mstep();
      @(negedge clk);
      check(tag);
   endtask

   task automatic run(input int n, input string tag);
      for (int k = 0; k < n; k++) cyc(tag);
   endtask

   initial begin
      mreset();
      @(negedge clk);
      check("reset");
      rst_n = 1'b1;
      en = 1'b1;
      run(60, "free");

      div_we = 1'b1; div_sel = 3'd1; div_wdata = 32'd3;
      cyc("wr_ch1");
      div_we = 1'b0;
      run(40, "ch1_new");

      div_we = 1'b1; div_sel = 3'd0; div_wdata = 32'd0;
      cyc("wr_ch0");
      div_we = 1'b0;
      sync_restart = 1'b1;
      cyc("restart");
      sync_restart = 1'b0;
      run(24, "half0");

      run(3, "pre_hold");
      en = 1'b0;
      run(37, "hold");
      en = 1'b1;
      run(30, "resume");

      for (int k = 0; k < 40 && dl[3] != ecnt + 1; k++) cyc("seek_wrap");
      tests++;
      assert (dl[3] == ecnt + 1) else begin
         fails++;
         $error("FAIL seek_wrap timeout got %0d want %0d", dl[3], ecnt + 1);
      end
      div_we = 1'b1; div_sel = 3'd3; div_wdata = 32'd1;
      cyc("wr_at_wrap");
      div_we = 1'b0;
      run(20, "ch3_new");

      div_we = 1'b1; div_sel = 3'd5; div_wdata = 32'd2;
      cyc("wr_oob");
      div_we = 1'b0;
      run(20, "after_oob");

      for (int k = 0; k < 400; k++) begin
         en = ($urandom_range(0, 9) != 0);
         sync_restart = ($urandom_range(0, 49) == 0);
         div_we = ($urandom_range(0, 4) == 0);
         div_sel = S'($urandom_range(0, 7));
         div_wdata = $urandom_range(0, 6);
         cyc("random");
      end
      en = 1'b1; sync_restart = 1'b0; div_we = 1'b0;
      run(10, "settle");

      div_we = 1'b1; div_sel = 3'd2; div_wdata = 32'd1;
      #2 rst_n = 1'b0;
      #1;
      tests++;
      assert (clk_out === '0 && tick === '0) else begin
         fails++;
         $error("FAIL async_rst got %b/%b want 0/0", clk_out, tick);
      end
      mreset();
      div_we = 1'b0;
      @(negedge clk);
      check("in_reset");
      rst_n = 1'b1;
      run(40, "post_reset");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/clk_div_bank.md
Name: clk_div_bank

Overview:
- Parametrised, run-time-programmable bank of NUM_CH independent clock dividers driven from the single system clock `clk`.
- Each channel produces:
  - a 50%-duty divided clock-enable waveform;
  - a one-cycle tick pulse for downstream logic that must stay in the `clk` domain.
- Divisors are written through a simple register port and take effect glitch-free at the channel's next wrap.
- A global restart re-aligns all channels in phase.

Parameters:
- NUM_CH, 4, number of divider channels (1..16).
- CNT_W, 32, width of each half-period counter and divisor register.
- INIT_HALF, {4{32'd49_999}}, packed NUM_CH*CNT_W reset value of each channel's half-period register (channel i at bits [i*CNT_W +: CNT_W]).
- SEL_W, 2, width of div_sel; must satisfy 2**SEL_W >= NUM_CH.

Ports:
- clk  in  1  system clock (100 MHz).
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  global count enable; when low all counters and outputs hold.
- sync_restart  in  1  synchronous pulse: realign all channels to phase 0.
- div_we  in  1  divisor write strobe.
- div_sel  in  SEL_W  channel index for write (and readback when enabled).
- div_wdata  in  CNT_W  new half-period value (output half-period = div_wdata+1 cycles).
- clk_out  out  NUM_CH  per-channel divided square wave, frequency f_clk / (2*(HALF+1)).
- tick  out  NUM_CH  per-channel one-cycle pulse, asserted in the cycle clk_out rises.

Behaviour:
- Reset (rst_n low, asynchronous):
  - cnt[i]=0, clk_out=0, tick=0;
  - active half[i] and shadow[i] = INIT_HALF slice;
  - pending[i]=0.
- Per channel, every clk with en=1 and sync_restart=0:
  - If cnt[i]==half[i]:
    - cnt[i]<=0, clk_out[i]<=~clk_out[i];
    - tick[i]<=1 iff clk_out[i] was 0 (rising transition), else 0;
    - if pending[i], half[i]<=shadow[i] and pending[i]<=0.
  - Else cnt[i]<=cnt[i]+1, tick[i]<=0.
- Divisor write:
  - div_we=1 with div_sel<NUM_CH: shadow[div_sel]<=div_wdata, pending<=1.
  - div_sel>=NUM_CH: write ignored.
  - The active half never changes mid-half-period, so there is no runt pulse.
  - A write in the same cycle as that channel's wrap is committed at the following wrap, not the current one.
  - A second write before commit overwrites the shadow; last write wins.
- half[i]==0: clk_out toggles every cycle (f_clk/2), tick every 2nd cycle.
- sync_restart=1 (priority over en and wrap):
  - all cnt<=0, clk_out<=0, tick<=0;
  - every pending shadow is committed immediately, pending cleared.
  - A div_we in the same cycle updates the shadow and sets pending; it is not committed until the next wrap or restart.
- en=0: cnt, clk_out and half hold; tick forced 0; divisor writes still accepted into the shadow.
- Latency: clk_out and tick are registered, so the first rising tick occurs (half+1) cycles after reset release or restart.
- Counter arithmetic is unsigned CNT_W; cnt never exceeds half, so no overflow path exists.
- rst_n asserted mid-period: outputs drop to 0 immediately (asynchronous); shadow writes in flight are lost.

Optional Feature:
- Macro: CLK_DIV_BANK_READBACK_EN.
- Defined:
  - adds output port div_rdata (CNT_W) = active half[div_sel] (combinational from registers);
  - adds output port div_pending (1) = pending[div_sel];
  - div_sel>=NUM_CH reads 0.
- Undefined: neither port exists; all other behaviour is identical.

Test Plan:
- Reset with defaults, INIT_HALF=49_999, run 400_000 cycles -> each clk_out period exactly 100_000 cycles, high 50_000 / low 50_000; tick count = 4, each spaced 100_000 cycles; all channels in phase.
- Write div_sel=1, div_wdata=3 mid-half-period -> channel 1 finishes its current 50_000-cycle half unchanged, then runs period 8 cycles; other channels unaffected; div_pending=1 until the wrap (readback build).
- Set half=0 on ch0 via write + sync_restart -> ch0 clk_out toggles every cycle, tick every 2 cycles starting 1 cycle after restart; ch2 with half=9 ticks first 10 cycles after restart.
- Hold en=0 for 37 cycles mid-count -> clk_out frozen, tick stays 0; after en=1 the remaining count resumes with total half-period = half+1+37 cycles.
- div_we on ch3 in the exact wrap cycle with wdata=1, INIT half 4 -> the next half still lasts 5 cycles, subsequent halves last 2; write with div_sel=3 and NUM_CH=3 -> no state change.
- Assert rst_n low for 1 cycle mid-period, asynchronously between clk edges -> clk_out and tick go 0 without waiting for clk; after release counting restarts from INIT_HALF with pending cleared.
